// File: rtl/vm2002_stock_arb_if.sv
// -----------------------------------------------------------------------------
// vm2002_stock_arb_if
// Request/response bundle between the stock arbiter and its two requesters.
//   supplier side : sup_valid, sup_item, sup_count, sup_cost -> arbiter
//                   sup_ready, sup_err                       <- arbiter
//   user side     : usr_req, usr_op, usr_item                 -> arbiter
//                   usr_ack, usr_status, usr_cost             <- arbiter
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface vm2002_stock_arb_if #(
   parameter int ITEM_W  = 3,
   parameter int COUNT_W = 4,
   parameter int COST_W  = 8
);
   logic                sup_valid;
   logic [ITEM_W-1:0]   sup_item;
   logic [COUNT_W-1:0]  sup_count;
   logic [COST_W-1:0]   sup_cost;
   logic                sup_ready;
   logic                sup_err;

   logic                usr_req;
   logic                usr_op;
   logic [ITEM_W-1:0]   usr_item;
   logic                usr_ack;
   logic [1:0]          usr_status;
   logic [COST_W-1:0]   usr_cost;

   modport master (
      output sup_valid, sup_item, sup_count, sup_cost,
      input  sup_ready, sup_err,
      output usr_req, usr_op, usr_item,
      input  usr_ack, usr_status, usr_cost
   );

   modport slave (
      input  sup_valid, sup_item, sup_count, sup_cost,
      output sup_ready, sup_err,
      input  usr_req, usr_op, usr_item,
      output usr_ack, usr_status, usr_cost
   );
endinterface

// File: rtl/vm2002_stock_arb.sv
// -----------------------------------------------------------------------------
// vm2002_stock_arb
// Vending-machine stock table (per-item count and cost) shared between the
// supplier restock port and the user vend controller. Requests are serialized
// through an IDLE -> RD -> WR read-modify-write sequence with round-robin
// arbitration; each transaction ends with a one-cycle completion pulse.
//
// Ports:
//   clk        system clock
//   hrst       synchronous active-high reset
//   bus        vm2002_stock_arb_if.slave (supplier and user handshakes)
//   busy       high while a transaction is in flight (state != IDLE)
//   low_stock  per-item low-stock flags (only with VM_STOCK_LOW_FLAG_EN)
//
// Optional feature macro: VM_STOCK_LOW_FLAG_EN
//   Adds parameter LOW_THRESH and output low_stock[NUM_ITEMS-1:0];
//   bit i = 1 iff count[i] <= LOW_THRESH after the last write of item i.
// -----------------------------------------------------------------------------
module vm2002_stock_arb #(
   parameter int NUM_ITEMS  = 8,
   parameter int COUNT_W    = 4,
   parameter int COST_W     = 8,
   parameter int MAX_COUNT  = 15
`ifdef VM_STOCK_LOW_FLAG_EN
  ,parameter int LOW_THRESH = 2
`endif
) (
   input  logic                 clk,
   input  logic                 hrst,
   vm2002_stock_arb_if.slave    bus,
   output logic                 busy
`ifdef VM_STOCK_LOW_FLAG_EN
  ,output logic [NUM_ITEMS-1:0] low_stock
`endif
);

   localparam int ITEM_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
   localparam logic [ITEM_W:0]  ITEM_LIM = (ITEM_W+1)'(NUM_ITEMS);
   localparam logic [COUNT_W:0] MAX_SUM  = (COUNT_W+1)'(MAX_COUNT);
`ifdef VM_STOCK_LOW_FLAG_EN
   localparam logic [COUNT_W-1:0] LOW_C = COUNT_W'(LOW_THRESH);
`endif

   typedef enum logic [1:0] {IDLE, RD, WR} state_t;
   typedef enum logic {GNT_SUP, GNT_USR} gnt_t;
   typedef enum logic [1:0] {
      ST_AVAIL = 2'b00,
      ST_OOS   = 2'b01,
      ST_ERR   = 2'b10
   } ustat_t;

   state_t               state, state_nxt;
   gnt_t                 gnt, gnt_nxt, rr_ptr;

   // Fields captured at grant; requester inputs are not looked at again.
   logic [ITEM_W-1:0]    g_item;
   logic                 g_op;
   logic [COUNT_W-1:0]   g_count;
   logic [COST_W-1:0]    g_cost;

   // Working copies of the table entry, loaded in RD.
   logic [COUNT_W-1:0]   cnt_w;
   logic [COST_W-1:0]    cost_w;

   logic [COUNT_W-1:0]   count_tbl [NUM_ITEMS];
   logic [COST_W-1:0]    cost_tbl  [NUM_ITEMS];

   logic                 sup_ready_q, sup_err_q, usr_ack_q;
   logic [1:0]           usr_status_q;
   logic [COST_W-1:0]    usr_cost_q;

   logic                 sup_elig, usr_elig;
   logic                 item_ok, sup_rej, tbl_we;
   logic [COUNT_W:0]     sum;
   ustat_t               ustat;
   logic [COUNT_W-1:0]   new_count;
   logic [COST_W-1:0]    new_cost;

   // A requester whose pulse is high this cycle is still dropping its
   // request, so it must not be granted again.
   assign sup_elig = bus.sup_valid && !sup_ready_q;
   assign usr_elig = bus.usr_req   && !usr_ack_q;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (hrst) state <= IDLE;
      else      state <= state_nxt;
   end

   // ---------------------------------------------------------- next-state comb
   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      unique case (state)
         IDLE: begin
            if (sup_elig && usr_elig) begin
               gnt_nxt   = (rr_ptr == GNT_SUP) ? GNT_USR : GNT_SUP;
               state_nxt = RD;
            end else if (sup_elig) begin
               gnt_nxt   = GNT_SUP;
               state_nxt = RD;
            end else if (usr_elig) begin
               gnt_nxt   = GNT_USR;
               state_nxt = RD;
            end
         end
         RD:      state_nxt = WR;
         WR:      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // -------------------------------------------------------------- output comb
   always_comb begin
      busy    = (state != IDLE);
      item_ok = ({1'b0, g_item} < ITEM_LIM);
      sum     = {1'b0, cnt_w} + {1'b0, g_count};
      sup_rej = !item_ok || (sum > MAX_SUM);

      if (!item_ok || cost_w == '0) ustat = ST_ERR;
      else if (cnt_w == '0)         ustat = ST_OOS;
      else                          ustat = ST_AVAIL;

      new_count = cnt_w;
      new_cost  = cost_w;
      if (gnt == GNT_SUP) begin
         if (!sup_rej) begin
            new_count = sum[COUNT_W-1:0];
            if (g_cost != '0) new_cost = g_cost;
         end
      end else if (g_op && ustat == ST_AVAIL) begin
         new_count = cnt_w - COUNT_W'(1);
      end

      tbl_we = (state == WR) && item_ok;
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (hrst) begin
         gnt          <= GNT_SUP;
         rr_ptr       <= GNT_USR;
         g_item       <= '0;
         g_op         <= 1'b0;
         g_count      <= '0;
         g_cost       <= '0;
         cnt_w        <= '0;
         cost_w       <= '0;
         count_tbl    <= '{default: '0};
         cost_tbl     <= '{default: '0};
         sup_ready_q  <= 1'b0;
         sup_err_q    <= 1'b0;
         usr_ack_q    <= 1'b0;
         usr_status_q <= '0;
         usr_cost_q   <= '0;
`ifdef VM_STOCK_LOW_FLAG_EN
         low_stock    <= '1;
`endif
      end else begin
         sup_ready_q <= 1'b0;
         usr_ack_q   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (state_nxt == RD) begin
                  gnt     <= gnt_nxt;
                  rr_ptr  <= gnt_nxt;
                  g_item  <= (gnt_nxt == GNT_SUP) ? bus.sup_item : bus.usr_item;
                  g_op    <= bus.usr_op;
                  g_count <= bus.sup_count;
                  g_cost  <= bus.sup_cost;
               end
            end
            RD: begin
               // Out-of-range index reads as an empty, unpriced entry.
               cnt_w  <= item_ok ? count_tbl[g_item] : '0;
               cost_w <= item_ok ? cost_tbl[g_item]  : '0;
            end
            WR: begin
               if (tbl_we) begin
                  count_tbl[g_item] <= new_count;
                  cost_tbl[g_item]  <= new_cost;
`ifdef VM_STOCK_LOW_FLAG_EN
                  low_stock[g_item] <= (new_count <= LOW_C);
`endif
               end
               if (gnt == GNT_SUP) begin
                  sup_ready_q <= 1'b1;
                  sup_err_q   <= sup_rej;
               end else begin
                  usr_ack_q    <= 1'b1;
                  usr_status_q <= ustat;
                  usr_cost_q   <= cost_w;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.sup_ready  = sup_ready_q;
   assign bus.sup_err    = sup_err_q;
   assign bus.usr_ack    = usr_ack_q;
   assign bus.usr_status = usr_status_q;
   assign bus.usr_cost   = usr_cost_q;

endmodule

// File: tb/tb_vm2002_stock_arb.sv
// -----------------------------------------------------------------------------
// tb_vm2002_stock_arb
// Directed bench for vm2002_stock_arb: single transactions, restock limits,
// arbitration under contention, mid-transaction reset and (when
// VM_STOCK_LOW_FLAG_EN is defined) the low-stock flags.
// -----------------------------------------------------------------------------
module tb_vm2002_stock_arb;

   localparam logic [1:0] AVAIL = 2'b00;
   localparam logic [1:0] OOS   = 2'b01;
   localparam logic [1:0] ERR   = 2'b10;

   logic clk = 1'b0;
   logic hrst;
   logic busy;
`ifdef VM_STOCK_LOW_FLAG_EN
   logic [7:0] low_stock;
`endif

   int vectors     = 0;
   int miscompares = 0;

   vm2002_stock_arb_if bus ();

   vm2002_stock_arb dut (
      .clk       (clk),
      .hrst      (hrst),
      .bus       (bus),
      .busy      (busy)
`ifdef VM_STOCK_LOW_FLAG_EN
     ,.low_stock (low_stock)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic reset_dut();
      @(negedge clk);
      bus.sup_valid = 1'b0;
      bus.usr_req   = 1'b0;
      hrst          = 1'b1;
      @(negedge clk);
      hrst          = 1'b0;
   endtask

   task automatic do_sup(input logic [2:0] item, input logic [3:0] cnt,
                         input logic [7:0] cost, input logic exp_err);
      int k;
      @(negedge clk);
      bus.sup_item  = item;
      bus.sup_count = cnt;
      bus.sup_cost  = cost;
      bus.sup_valid = 1'b1;
      @(negedge clk);
      check("sup_busy", busy, 1);
      k = 1;
      while (!bus.sup_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("sup_latency", k, 3);
      check("sup_err", bus.sup_err, exp_err);
      bus.sup_valid = 1'b0;
   endtask

   task automatic do_usr(input logic op, input logic [2:0] item,
                         input logic [1:0] exp_stat, input logic [7:0] exp_cost);
      int k;
      @(negedge clk);
      bus.usr_op   = op;
      bus.usr_item = item;
      bus.usr_req  = 1'b1;
      @(negedge clk);
      check("usr_busy", busy, 1);
      k = 1;
      while (!bus.usr_ack && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("usr_latency", k, 3);
      check("usr_status", bus.usr_status, exp_stat);
      check("usr_cost", bus.usr_cost, exp_cost);
      bus.usr_req = 1'b0;
   endtask

   initial begin
      int s_n[$];
      int u_n[$];
      int ack_seen;
      int k;

      hrst          = 1'b1;
      bus.sup_valid = 1'b0;
      bus.sup_item  = '0;
      bus.sup_count = '0;
      bus.sup_cost  = '0;
      bus.usr_req   = 1'b0;
      bus.usr_op    = 1'b0;
      bus.usr_item  = '0;
      repeat (2) @(negedge clk);
      hrst = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_busy", busy, 0);
      check("rst_sup_ready", bus.sup_ready, 0);
      check("rst_sup_err", bus.sup_err, 0);
      check("rst_usr_ack", bus.usr_ack, 0);
      check("rst_usr_status", bus.usr_status, 0);
      check("rst_usr_cost", bus.usr_cost, 0);
`ifdef VM_STOCK_LOW_FLAG_EN
      check("rst_low_stock", low_stock, 8'hFF);
`endif

      // Empty unpriced entry
      do_usr(1'b0, 3'd2, ERR, 8'd0);

      // Restock then drain item 2
      do_sup(3'd2, 4'd5, 8'd75, 1'b0);
      do_usr(1'b1, 3'd2, AVAIL, 8'd75);
      do_usr(1'b0, 3'd2, AVAIL, 8'd75);
      for (int i = 0; i < 4; i++) do_usr(1'b1, 3'd2, AVAIL, 8'd75);
      do_usr(1'b1, 3'd2, OOS, 8'd75);
      do_usr(1'b0, 3'd2, OOS, 8'd75);

      // Capacity boundary: 10+6 rejected (cost kept), 10+5 fills, +1 rejected
      do_sup(3'd2, 4'd10, 8'd0, 1'b0);
      do_sup(3'd2, 4'd6, 8'd33, 1'b1);
      do_usr(1'b0, 3'd2, AVAIL, 8'd75);
      do_sup(3'd2, 4'd5, 8'd0, 1'b0);
      do_sup(3'd2, 4'd1, 8'd0, 1'b1);
      do_sup(3'd2, 4'd0, 8'd90, 1'b0);
      do_usr(1'b0, 3'd2, AVAIL, 8'd90);

      // Stocked but unpriced item reports ERROR
      do_sup(3'd3, 4'd2, 8'd0, 1'b0);
      do_usr(1'b0, 3'd3, ERR, 8'd0);

      // Highest index at full capacity
      do_sup(3'd7, 4'd15, 8'd255, 1'b0);
      do_sup(3'd7, 4'd1, 8'd0, 1'b1);
      do_usr(1'b1, 3'd7, AVAIL, 8'd255);

      // Contention from reset: SUP, USR, SUP with sup_valid held throughout
      reset_dut();
      @(negedge clk);
      bus.sup_item  = 3'd4;
      bus.sup_count = 4'd3;
      bus.sup_cost  = 8'd20;
      bus.sup_valid = 1'b1;
      bus.usr_op    = 1'b1;
      bus.usr_item  = 3'd4;
      bus.usr_req   = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (bus.usr_ack) begin
            u_n.push_back(n);
            check("c1_usr_status", bus.usr_status, AVAIL);
            check("c1_usr_cost", bus.usr_cost, 8'd20);
            bus.usr_req = 1'b0;
         end
         if (bus.sup_ready) begin
            s_n.push_back(n);
            check("c1_sup_err", bus.sup_err, 0);
            if (s_n.size() == 1) begin
               bus.sup_count = 4'd1;
               bus.sup_cost  = 8'd0;
            end else begin
               bus.sup_valid = 1'b0;
            end
         end
      end
      check("c1_sup_pulses", s_n.size(), 2);
      check("c1_sup_first", (s_n.size() > 0) ? s_n[0] : -1, 3);
      check("c1_sup_second", (s_n.size() > 1) ? s_n[1] : -1, 9);
      check("c1_usr_pulses", u_n.size(), 1);
      check("c1_usr_first", (u_n.size() > 0) ? u_n[0] : -1, 6);

      // Contention with rr pointer at SUP: user wins (item 4: 3 -> 2 -> 15)
      s_n.delete();
      u_n.delete();
      @(negedge clk);
      bus.sup_item  = 3'd4;
      bus.sup_count = 4'd13;
      bus.sup_cost  = 8'd0;
      bus.sup_valid = 1'b1;
      bus.usr_op    = 1'b1;
      bus.usr_item  = 3'd4;
      bus.usr_req   = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (bus.usr_ack) begin
            u_n.push_back(n);
            check("c2_usr_status", bus.usr_status, AVAIL);
            bus.usr_req = 1'b0;
         end
         if (bus.sup_ready) begin
            s_n.push_back(n);
            check("c2_sup_err", bus.sup_err, 0);
            bus.sup_valid = 1'b0;
         end
      end
      check("c2_usr_first", (u_n.size() > 0) ? u_n[0] : -1, 3);
      check("c2_sup_first", (s_n.size() > 0) ? s_n[0] : -1, 6);
      check("c2_pulses", s_n.size() + u_n.size(), 2);
      do_sup(3'd4, 4'd1, 8'd0, 1'b1);

      // Fields changed after grant are ignored: TAKE item 4 stands
      @(negedge clk);
      bus.usr_op   = 1'b1;
      bus.usr_item = 3'd4;
      bus.usr_req  = 1'b1;
      @(negedge clk);
      bus.usr_op   = 1'b0;
      bus.usr_item = 3'd5;
      k = 1;
      while (!bus.usr_ack && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("hold_latency", k, 3);
      check("hold_status", bus.usr_status, AVAIL);
      check("hold_cost", bus.usr_cost, 8'd20);
      bus.usr_req = 1'b0;
      do_sup(3'd4, 4'd2, 8'd0, 1'b1);
      do_sup(3'd4, 4'd1, 8'd0, 1'b0);

      // Reset while a TAKE is in RD: abandoned, table cleared
      reset_dut();
      do_sup(3'd2, 4'd3, 8'd40, 1'b0);
      @(negedge clk);
      bus.usr_op   = 1'b1;
      bus.usr_item = 3'd2;
      bus.usr_req  = 1'b1;
      @(negedge clk);
      check("rd_busy", busy, 1);
      hrst = 1'b1;
      @(negedge clk);
      hrst        = 1'b0;
      bus.usr_req = 1'b0;
      ack_seen    = 0;
      repeat (6) begin
         if (bus.usr_ack) ack_seen++;
         @(negedge clk);
      end
      check("rst_rd_no_ack", ack_seen, 0);
      check("rst_rd_busy", busy, 0);
      do_usr(1'b0, 3'd2, ERR, 8'd0);

`ifdef VM_STOCK_LOW_FLAG_EN
      check("low_after_rst", low_stock, 8'hFF);
      do_sup(3'd1, 4'd3, 8'd50, 1'b0);
      check("low_above", low_stock, 8'hFD);
      do_usr(1'b1, 3'd1, AVAIL, 8'd50);
      check("low_at_thresh", low_stock, 8'hFF);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vm2002_stock_arb.md
Name: vm2002_stock_arb

Overview:
Owns the vending machine's stock table: per-item count and cost. Arbitrates access to it between two requesters, the supplier restock port and the user-side vend controller. Transactions are serialized through a 3-state read-modify-write FSM with round-robin arbitration. Each transaction gets a one-cycle completion pulse with a status code.

Parameters:
NUM_ITEMS, 8, number of table entries; item index width is clog2(NUM_ITEMS), 3 at default
COUNT_W, 4, width of each stock count
COST_W, 8, width of each cost entry, in cents
MAX_COUNT, 15, stock capacity per item; must be <= 2**COUNT_W-1

Ports:
clk  in  1  system clock
hrst  in  1  synchronous active-high reset
sup_valid  in  1  restock request; held with its fields until sup_ready
sup_item  in  3  item index to restock
sup_count  in  COUNT_W  units to add
sup_cost  in  COST_W  new cost; 0 = keep current cost
sup_ready  out  1  one-cycle completion pulse for a restock
sup_err  out  1  restock rejected; valid only while sup_ready=1
usr_req  in  1  user request; held with its fields until usr_ack
usr_op  in  1  0=QUERY, 1=TAKE (decrement one unit)
usr_item  in  3  item index
usr_ack  out  1  one-cycle completion pulse for a user request
usr_status  out  2  00=AVAILABLE, 01=OUT_OF_STOCK, 10=ERROR; valid only while usr_ack=1
usr_cost  out  COST_W  cost of the item; valid only while usr_ack=1
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (hrst=1 at a clock edge), regardless of current state:
  - state<=IDLE; all counts and costs <=0; rr pointer <=USER, so the supplier wins the first contention.
  - sup_ready, sup_err, usr_ack, usr_status, usr_cost, busy all <=0.
  - An in-flight transaction is abandoned with no table write and no completion pulse.
- FSM states: IDLE, RD, WR.
  - IDLE: if any eligible request is pending, latch the grant (SUP or USR), item, op and fields; go to RD. Otherwise stay.
  - RD: latch count[item] and cost[item] into working registers; go to WR.
  - WR: compute the result, write the table, register the completion pulse and status; go to IDLE.
- Latency: request sampled at edge E0, RD at E1, WR at E2. The completion pulse is high for exactly the cycle after E2. Maximum throughput is one transaction per 3 cycles.
- Eligibility: a requester whose ready/ack is high in the current cycle is ignored by IDLE in that cycle. This prevents a double-service while it drops its request.
- Arbitration: if both requesters are eligible in IDLE, grant the one not equal to the rr pointer. The rr pointer updates to the granted requester on every grant. A single eligible requester always wins.
- Restock (WR):
  - If sup_item >= NUM_ITEMS, or count+sup_count > MAX_COUNT (sum computed COUNT_W+1 bits wide): sup_err=1, table unchanged, including cost.
  - Otherwise: count <= count+sup_count; cost <= sup_cost if sup_cost != 0.
  - sup_count=0 with nonzero sup_cost is a legal price-only update.
- User QUERY (WR), evaluated in priority order:
  - usr_item >= NUM_ITEMS or cost==0 (unpriced): ERROR.
  - count==0: OUT_OF_STOCK.
  - Otherwise: AVAILABLE.
  - usr_cost = table cost in all cases (0 on a bad index). Table unchanged.
- User TAKE (WR): status evaluated as for QUERY; count decrements by 1 only when the status is AVAILABLE. Count never wraps below 0.
- Requester fields are not re-sampled after grant. Changing them mid-transaction has no effect.
- busy = (state != IDLE).

Optional Feature:
VM_STOCK_LOW_FLAG_EN
- Defined:
  - Adds parameter LOW_THRESH (default 2) and output low_stock [NUM_ITEMS-1:0].
  - Bit i is registered and updated in WR for the written item: 1 iff the new count <= LOW_THRESH.
  - All bits reset to 1 (the table starts empty).
- Undefined: port and logic absent.

Test Plan:
1. After reset, usr_req QUERY item 2 -> usr_ack 3 cycles after request sampled; usr_status=ERROR (cost 0); usr_cost=0.
2. Restock item 2: count=5, cost=8'd75 -> sup_ready, sup_err=0. Then TAKE item 2 -> AVAILABLE, usr_cost=75. Then QUERY -> AVAILABLE; count reads 4 (verify with TAKE x4, then 5th TAKE -> OUT_OF_STOCK).
3. Item 2 count=10, restock count=6 -> sup_err=1; count stays 10. Restock count=5 -> accepted, count=15. Restock count=0, cost=90 -> accepted; subsequent usr_cost=90.
4. sup_valid and usr_req rise in the same cycle, held continuously -> supplier granted first (rr reset); user next; grants alternate SUP,USR,SUP and each requester completes exactly once per assertion.
5. Assert hrst in RD of a TAKE on item 2 (count 3) -> no usr_ack; table fully cleared; following QUERY -> ERROR.
6. (VM_STOCK_LOW_FLAG_EN) Restock item 1 count=3, cost=50 -> low_stock[1]=0. One TAKE -> count 2 -> low_stock[1]=1; other bits remain 1.
